ic_refill_responder: RTL and testbench

IC_REFILL_RESPONDER -- requirements
Module: ic_refill_responder

---
 rtl/ic_refill_responder.sv | 102 ++++++++++
 tb/tb_ic_refill_responder.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ic_refill_responder.sv
// ic_refill_responder: queued icache line refill responder with fixed request-to-response latency
module ic_refill_responder #(
  parameter int LINE_SIZE      = 256,
  parameter int ADDR_W         = 26,
  parameter int MEM_LINES_LOG2 = 10,
  parameter int LATENCY        = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      ic_valid_i,
  input  logic [ADDR_W-1:0]         ic_addr_i,
  output logic                      ic_ready_o,
  output logic                      ic_valid_o,
  output logic [LINE_SIZE-1:0]      ic_line_o,
  output logic [7:0]                ic_seq_num_o,
  input  logic                      pl_we_i,
  input  logic [MEM_LINES_LOG2-1:0] pl_addr_i,
  input  logic [LINE_SIZE-1:0]      pl_line_i,
  output logic                      overflow_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t                    r_state, w_next;
  logic [MEM_LINES_LOG2-1:0] r_fifo [FIFO_DEPTH];
  logic [LINE_SIZE-1:0]      r_mem [2**MEM_LINES_LOG2];
  logic [LINE_SIZE-1:0]      r_rdata;
  logic [PW-1:0]             r_wp, r_rp, w_occ;
  logic [7:0]                r_cnt, w_cnt_next, r_seq;
  logic [MEM_LINES_LOG2-1:0] r_addr, w_head, w_rd_idx;
  logic                      r_ovf, w_push, w_pop, w_rd, w_empty;
  logic                      w_unused;
  // Only the low index bits select a backing-store line; the rest are ignored.
  assign w_unused   = ^ic_addr_i[ADDR_W-1:MEM_LINES_LOG2];
  assign w_occ      = r_wp - r_rp;
  assign w_empty    = r_wp == r_rp;
  assign ic_ready_o = w_occ < PW'(FIFO_DEPTH);
  assign w_push     = ic_valid_i && ic_ready_o;
  assign w_head     = r_fifo[r_rp[AW-1:0]];
  assign ic_valid_o   = r_state == RESP;
  assign ic_line_o    = ic_valid_o ? r_rdata : '0;
  assign ic_seq_num_o = r_seq;
  assign overflow_o   = r_ovf;
  // Next-state logic: IDLE pops, WAIT counts down and reads the line in its last cycle, RESP emits.
  always_comb begin
    w_next     = r_state;
    w_pop      = 1'b0;
    w_rd       = 1'b0;
    w_cnt_next = r_cnt;
    w_rd_idx   = r_addr;
    case (r_state)
      IDLE: if (!w_empty) begin
        w_pop      = 1'b1;
        w_cnt_next = 8'(LATENCY - 2);
        w_next     = (LATENCY == 2) ? RESP : WAIT;
        w_rd       = LATENCY == 2;
        w_rd_idx   = w_head;
      end
      WAIT: begin
        w_cnt_next = r_cnt - 8'd1;
        if (r_cnt <= 8'd1) begin
          w_next = RESP;
          w_rd   = 1'b1;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // Control state: FSM, queue pointers, latency counter, sequence number and sticky overflow.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_seq   <= '0;
      r_addr  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_pop) begin
        r_rp   <= r_rp + PW'(1);
        r_addr <= w_head;
      end
      if (r_state == RESP) r_seq <= r_seq + 8'd1;
      if (ic_valid_i && !ic_ready_o) r_ovf <= 1'b1;
    end
  end
  // Queue storage needs no reset: pointers alone define which entries are live.
  always_ff @(posedge clk_i) begin
    if (w_push) r_fifo[r_wp[AW-1:0]] <= ic_addr_i[MEM_LINES_LOG2-1:0];
  end
  // Backing store survives reset; a same-edge preload to the read index returns the old line.
  always_ff @(posedge clk_i) begin
    if (pl_we_i) r_mem[pl_addr_i] <= pl_line_i;
    if (w_rd) r_rdata <= r_mem[w_rd_idx];
  end
endmodule

// File: tb/tb_ic_refill_responder.sv
// tb_ic_refill_responder: directed self-checking bench for ic_refill_responder
module tb_ic_refill_responder;
  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         ic_valid_i = 1'b0;
  logic [25:0]  ic_addr_i = '0;
  logic         ic_ready_o, ic_valid_o, overflow_o;
  logic [255:0] ic_line_o;
  logic [7:0]   ic_seq_num_o;
  logic         pl_we_i = 1'b0;
  logic [9:0]   pl_addr_i = '0;
  logic [255:0] pl_line_i = '0;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic        v;
    logic [25:0] a;
    logic        ev;
    int          la;
    int          seq;
  } vec_t;
  vec_t tbl [20];
  ic_refill_responder dut (
    .clk_i(clk_i), .rst_i(rst_i), .ic_valid_i(ic_valid_i), .ic_addr_i(ic_addr_i),
    .ic_ready_o(ic_ready_o), .ic_valid_o(ic_valid_o), .ic_line_o(ic_line_o),
    .ic_seq_num_o(ic_seq_num_o), .pl_we_i(pl_we_i), .pl_addr_i(pl_addr_i),
    .pl_line_i(pl_line_i), .overflow_o(overflow_o)
  );
  always #5 clk_i = ~clk_i;
  function automatic logic [255:0] pat(input int i);
    return (i == 5) ? {32{8'hA5}} : {8{32'hC0DE_0000 | 32'(i)}};
  endfunction
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask
  task automatic do_reset();
    rst_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask
  task automatic req(input int a, input logic [255:0] line, input int seq, input bit pl,
                     input logic [255:0] pl_new, input string nm);
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk_i);
      if (k > 0) begin
        chk({nm, "_valid"}, 256'(ic_valid_o), 256'(k == 4));
        chk({nm, "_line"}, ic_line_o, (k == 4) ? line : '0);
        if (k == 4) chk({nm, "_seq"}, 256'(ic_seq_num_o), 256'(seq));
      end
      ic_valid_i = k == 0;
      ic_addr_i  = 26'(a);
      pl_we_i    = pl && k == 3;
      pl_addr_i  = 10'd7;
      pl_line_i  = pl_new;
    end
    ic_valid_i = 1'b0;
    pl_we_i    = 1'b0;
  endtask
  initial begin
    int sent, got, cyc;
    int q[$];
    logic [255:0] exp_line;
    @(negedge clk_i);
    chk("rst_valid", 256'(ic_valid_o), 256'(0));
    chk("rst_line", ic_line_o, '0);
    chk("rst_ready", 256'(ic_ready_o), 256'(1));
    chk("rst_ovf", 256'(overflow_o), 256'(0));
    chk("rst_seq", 256'(ic_seq_num_o), 256'(0));
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_i);
      pl_we_i = 1'b1;
      pl_addr_i = 10'(i);
      pl_line_i = pat(i);
    end
    @(negedge clk_i);
    pl_we_i = 1'b0;
    req(5, {32{8'hA5}}, 0, 1'b0, '0, "single");
    for (int i = 0; i < 20; i++) begin
      tbl[i].v   = i < 4;
      tbl[i].a   = 26'(i + 1);
      tbl[i].ev  = (i % 4 == 0) && i > 0 && i <= 16;
      tbl[i].la  = i / 4;
      tbl[i].seq = i / 4;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      chk($sformatf("tbl%0d_valid", i), 256'(ic_valid_o), 256'(tbl[i].ev));
      chk($sformatf("tbl%0d_line", i), ic_line_o, tbl[i].ev ? pat(tbl[i].la) : '0);
      chk($sformatf("tbl%0d_ready", i), 256'(ic_ready_o), 256'(1));
      if (tbl[i].ev) chk($sformatf("tbl%0d_seq", i), 256'(ic_seq_num_o), 256'(tbl[i].seq));
      ic_valid_i = tbl[i].v;
      ic_addr_i  = tbl[i].a;
    end
    ic_valid_i = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk_i);
      if (k < 6) chk($sformatf("ovf%0d_ready", k), 256'(ic_ready_o), 256'(k != 5));
      chk($sformatf("ovf%0d_flag", k), 256'(overflow_o), 256'(k >= 6));
      chk($sformatf("ovf%0d_valid", k), 256'(ic_valid_o), 256'(k % 4 == 0 && k >= 4 && k <= 20));
      if (k % 4 == 0 && k >= 4 && k <= 20) begin
        chk($sformatf("ovf%0d_line", k), ic_line_o, pat(10 + k / 4 - 1));
        chk($sformatf("ovf%0d_seq", k), 256'(ic_seq_num_o), 256'(5 + k / 4 - 1));
      end
      ic_valid_i = k < 6;
      ic_addr_i  = 26'(10 + k);
    end
    ic_valid_i = 1'b0;
    chk("ovf_ready_end", 256'(ic_ready_o), 256'(1));
    do_reset();
    chk("rst2_ovf", 256'(overflow_o), 256'(0));
    chk("rst2_seq", 256'(ic_seq_num_o), 256'(0));
    sent = 0;
    got = 0;
    cyc = 0;
    while (got < 257 && cyc < 3000) begin
      @(negedge clk_i);
      cyc++;
      if (ic_valid_o) begin
        exp_line = (q.size() > 0) ? pat(q.pop_front()) : 'x;
        chk($sformatf("seqrun%0d_seq", got), 256'(ic_seq_num_o), 256'(got % 256));
        chk($sformatf("seqrun%0d_line", got), ic_line_o, exp_line);
        got++;
      end
      if (ic_ready_o && sent < 257) begin
        ic_valid_i = 1'b1;
        ic_addr_i  = 26'(sent % 16);
        q.push_back(sent % 16);
        sent++;
      end else ic_valid_i = 1'b0;
    end
    ic_valid_i = 1'b0;
    chk("seqrun_count", 256'(got), 256'(257));
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_i);
      chk("seqrun_extra", 256'(ic_valid_o), 256'(0));
    end
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk_i);
      ic_valid_i = k < 3;
      ic_addr_i  = 26'(k + 1);
    end
    rst_i = 1'b1;
    #1;
    chk("midrst_ready", 256'(ic_ready_o), 256'(1));
    chk("midrst_valid", 256'(ic_valid_o), 256'(0));
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_i);
      chk("midrst_quiet", 256'(ic_valid_o), 256'(0));
      chk("midrst_ready_after", 256'(ic_ready_o), 256'(1));
    end
    req(6, pat(6), 0, 1'b0, '0, "afterrst");
    req(7, pat(7), 1, 1'b1, {8{32'h7E57_0007}}, "plold");
    req(7, {8{32'h7E57_0007}}, 2, 1'b0, '0, "plnew");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
